// File: rtl/sort_controller.sv
`default_nettype none
// ============================================================================
// sort_controller -- loads a batch into slot registers, then emits it in the
// order chosen by an external min-finding engine (FO) over the valid tags.
// Revision: 1.0
// ============================================================================
module sort_controller #(
  parameter int ELEMENT_NUM      = 32,
  parameter int DATA_WIDTH       = 8,
  parameter int LOG2_ELEMENT_NUM = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [LOG2_ELEMENT_NUM-1:0]       out_index,
  output logic                              out_last,
  output logic [ELEMENT_NUM-1:0]            EVT,
  output logic [ELEMENT_NUM*DATA_WIDTH-1:0] whole_UM,
  input  logic [LOG2_ELEMENT_NUM-1:0]       FO
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SELECT = 2'd1,
    EMIT   = 2'd2
  } state_t;

  localparam logic [LOG2_ELEMENT_NUM-1:0] c_LAST_SLOT = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

  state_t                        r_state;
  state_t                        w_next;
  logic [LOG2_ELEMENT_NUM-1:0]   r_cnt;
  logic [ELEMENT_NUM-1:0]        r_evt;
  logic [ELEMENT_NUM-1:0]        w_evt_after_pick;
  logic [DATA_WIDTH-1:0]         r_slot [ELEMENT_NUM];
  logic [DATA_WIDTH-1:0]         r_out_data;
  logic [LOG2_ELEMENT_NUM-1:0]   r_out_index;
  logic                          r_out_last;
  logic                          w_load;
  logic                          w_load_done;
  logic                          w_select;

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_done = 1'b0;
    w_select    = 1'b0;
    case (r_state)
      LOAD: begin
        if (in_valid) begin
          w_load = 1'b1;
          // The final slot closes the batch whether or not in_last is set.
          if (in_last || (r_cnt == c_LAST_SLOT)) begin
            w_load_done = 1'b1;
            w_next      = SELECT;
          end
        end
      end
      SELECT: begin
        w_select = 1'b1;
        w_next   = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          w_next = r_out_last ? LOAD : SELECT;
        end
      end
      default: w_next = LOAD;
    endcase
  end

  assign w_evt_after_pick = r_evt & ~(ELEMENT_NUM'(1) << FO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_evt       <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_load) begin
        r_evt[r_cnt] <= 1'b1;
        r_cnt        <= w_load_done ? '0 : r_cnt + LOG2_ELEMENT_NUM'(1);
      end
      if (w_select) begin
        r_evt       <= w_evt_after_pick;
        r_out_index <= FO;
        r_out_data  <= r_slot[FO];
        r_out_last  <= (w_evt_after_pick == '0);
      end
    end
  end

  // Slot data is masked by EVT, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_slot[r_cnt] <= in_data;
    end
  end

  generate
    for (genvar gi = 0; gi < ELEMENT_NUM; gi++) begin : g_um
      assign whole_UM[gi*DATA_WIDTH +: DATA_WIDTH] = r_slot[gi];
    end
  endgenerate

  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == EMIT);
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign EVT       = r_evt;

endmodule
`default_nettype wire

// File: doc/sort_controller.md
SORT_CONTROLLER -- requirements
Module: sort_controller

Interface
REQ-001 Parameters SHALL be: ELEMENT_NUM, default 32, number of sorter slots; DATA_WIDTH, default 8, element width; LOG2_ELEMENT_NUM, default 5, slot index width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  load element offered.
REQ-005 in_ready  output  1  controller accepts a load element this cycle.
REQ-006 in_data  input  DATA_WIDTH  element value (two's complement).
REQ-007 in_last  input  1  marks the final element of the batch.
REQ-008 out_valid  output  1  sorted element presented.
REQ-009 out_ready  input  1  downstream accepts the presented element.
REQ-010 out_data  output  DATA_WIDTH  sorted element value.
REQ-011 out_index  output  LOG2_ELEMENT_NUM  slot the element was loaded into.
REQ-012 out_last  output  1  final element of the batch.
REQ-013 EVT  output  ELEMENT_NUM  element-valid tags to the sorting engine.
REQ-014 whole_UM  output  ELEMENT_NUM*DATA_WIDTH  unsorted memory to the engine; slot i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-015 FO  input  LOG2_ELEMENT_NUM  engine result: index of the next element in ascending signed order among set EVT bits.

Function
REQ-016 States SHALL be LOAD, SELECT and EMIT; reset state is LOAD.
REQ-017 LOAD: in_ready=1, out_valid=0; on in_valid, write in_data to slot cnt, set EVT[cnt], increment cnt.
REQ-018 LOAD exit: the accepted element has in_last=1, or cnt==ELEMENT_NUM-1 at acceptance -> SELECT next cycle; in_last is ignored on the implicit final slot.
REQ-019 Batch size SHALL be 1..ELEMENT_NUM; unloaded slots keep EVT=0 and never appear on the output.
REQ-020 SELECT (one cycle, in_ready=0, out_valid=0): register out_index<=FO and out_data<=slot[FO], clear EVT[FO], out_last<=((EVT & ~onehot(FO))==0) -> EMIT.
REQ-021 EMIT: out_valid=1 with out_data/out_index/out_last stable until out_ready; on out_valid&&out_ready: out_last=1 -> LOAD with cnt=0, else -> SELECT.
REQ-022 The engine SHALL only be consulted in SELECT, where EVT is never all-zero; FO is don't-care elsewhere.
REQ-023 Throughput: one element every 2 cycles with out_ready held high; first out_valid asserts exactly 2 cycles after the cycle in which the last load element is accepted.
REQ-024 A batch of K elements SHALL produce exactly K output transfers, each slot exactly once, out_last on the K-th only.
REQ-025 in_valid outside LOAD SHALL be ignored (in_ready=0, no state change); out_ready outside EMIT is ignored.
REQ-026 whole_UM SHALL be driven from the slot registers; slot contents persist until overwritten by a later load.
REQ-027 Ties (equal values) SHALL be emitted in the order the engine selects them; the controller does not reorder.

Reset
REQ-028 rst SHALL force, on the next rising edge: state=LOAD, cnt=0, EVT=0, in_ready=1, out_valid=0, out_last=0, out_data=0, out_index=0.
REQ-029 rst in any state (including mid-EMIT with out_valid high) SHALL abandon the batch; the next transfer is a new load.
REQ-030 Slot data registers need not be reset; EVT=0 masks them.

Verification
REQ-031 Load 5, -3, 7 (in_last on 7), out_ready=1 -> outputs -3(idx1), 5(idx0), 7(idx2,last); first out_valid 2 cycles after 7 accepted.
REQ-032 Load 32 values 31..0 without in_last -> SELECT entered after 32nd; outputs 0..31 ascending, out_last only on 31, in_ready=0 throughout.
REQ-033 Single element 0x80 with in_last -> one transfer out_data=0x80 idx0 out_last=1, then in_ready=1.
REQ-034 out_ready low 3 cycles in EMIT -> out_data/out_index/out_last held, EVT unchanged, no element lost or duplicated.
REQ-035 Load 4, 4, 1 -> outputs 1, 4, 4 with indices {2, then 0 and 1 in engine order}, each once.
REQ-036 rst asserted during second EMIT of a 3-element batch -> next cycle EVT=0, out_valid=0, in_ready=1; new batch 9, 2 sorts to 2, 9.
